// File: rtl/metaballs_pkg.sv
// Shared widths, sequencer state encoding and screen-centre helpers
// for the metaball motion sequencer.
package metaballs_pkg;

  localparam int FIX_W = 12;
  localparam int VEL_W = 10;
  localparam int PIX_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    WRITE,
    COMMIT
  } seq_state_t;

  // Top-left coordinate that centres a ball on one axis, in 10.2 fixed point
  function automatic logic [FIX_W-1:0] center_fix(input int screen, input int ball);
    return FIX_W'(((screen - ball) / 2) << 2);
  endfunction

  function automatic logic [FIX_W-1:0] center_x(input int screen_width, input int ball_size);
    return center_fix(screen_width, ball_size);
  endfunction

  function automatic logic [FIX_W-1:0] center_y(input int screen_height, input int ball_size);
    return center_fix(screen_height, ball_size);
  endfunction

endpackage

// File: rtl/motion_alu.sv
// One axis of the shared motion datapath: advance the position by the
// velocity, then nudge the velocity one quarter-pixel toward the centre.
// All arithmetic wraps; there is no saturation.
module motion_alu
  import metaballs_pkg::*;
(
  input  logic [FIX_W-1:0] pos,
  input  logic [VEL_W-1:0] vel,
  input  logic [FIX_W-1:0] center,
  output logic [FIX_W-1:0] next_pos,
  output logic [VEL_W-1:0] next_vel
);

  logic [FIX_W-1:0] vel_ext;

  // Sign-extend the velocity, add it to the position, and steer toward the centre
  always_comb begin
    vel_ext  = {{(FIX_W - VEL_W){vel[VEL_W-1]}}, vel};
    next_pos = pos + vel_ext;
    if (next_pos < center) begin
      next_vel = vel + VEL_W'(1);
    end else begin
      next_vel = vel - VEL_W'(1);
    end
  end

endmodule

// File: rtl/ball_motion_sequencer.sv
// Per-frame motion sequencer: on each v_sync falling edge it walks every
// ball through one shared LOAD/CALC/WRITE datapath, then publishes all
// new integer positions together in a single COMMIT cycle.
module ball_motion_sequencer
  import metaballs_pkg::*;
#(
  parameter int                      NUM_BALLS     = 2,
  parameter int                      SCREEN_WIDTH  = 800,
  parameter int                      SCREEN_HEIGHT = 600,
  parameter int                      BALL_SIZE     = 128,
  parameter logic [10*NUM_BALLS-1:0] START_X       = {10'd425, 10'd224},
  parameter logic [10*NUM_BALLS-1:0] START_Y       = {10'd188, 10'd157}
) (
  input  logic                       clk_50mhz,
  input  logic                       reset,
  input  logic                       v_sync,
  input  logic                       pause,
  output logic [PIX_W*NUM_BALLS-1:0] ball_x,
  output logic [PIX_W*NUM_BALLS-1:0] ball_y,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun
);

  localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);
  localparam logic [FIX_W-1:0] CX = center_x(SCREEN_WIDTH, BALL_SIZE);
  localparam logic [FIX_W-1:0] CY = center_y(SCREEN_HEIGHT, BALL_SIZE);

  seq_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             v_sync_q;
  logic             tick;

  logic [FIX_W-1:0] pos_x [NUM_BALLS];
  logic [FIX_W-1:0] pos_y [NUM_BALLS];
  logic [VEL_W-1:0] vel_x [NUM_BALLS];
  logic [VEL_W-1:0] vel_y [NUM_BALLS];

  logic [FIX_W-1:0] op_px, op_py;
  logic [VEL_W-1:0] op_vx, op_vy;
  logic [FIX_W-1:0] res_px, res_py;
  logic [VEL_W-1:0] res_vx, res_vy;

  logic [FIX_W-1:0] alu_px, alu_py;
  logic [VEL_W-1:0] alu_vx, alu_vy;

  assign tick = v_sync_q & ~v_sync;

  motion_alu alu_x (
    .pos      (op_px),
    .vel      (op_vx),
    .center   (CX),
    .next_pos (alu_px),
    .next_vel (alu_vx)
  );

  motion_alu alu_y (
    .pos      (op_py),
    .vel      (op_vy),
    .center   (CY),
    .next_pos (alu_py),
    .next_vel (alu_vy)
  );

  // Sequencer FSM with ball state storage and registered outputs; the last
  // WRITE bypasses the freshly computed ball so COMMIT shows a whole frame
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      v_sync_q   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      op_px      <= '0;
      op_py      <= '0;
      op_vx      <= '0;
      op_vy      <= '0;
      res_px     <= '0;
      res_py     <= '0;
      res_vx     <= '0;
      res_vy     <= '0;
      ball_x     <= START_X;
      ball_y     <= START_Y;
      for (int i = 0; i < NUM_BALLS; i++) begin
        pos_x[i] <= {START_X[PIX_W*i +: PIX_W], 2'b00};
        pos_y[i] <= {START_Y[PIX_W*i +: PIX_W], 2'b00};
        vel_x[i] <= '0;
        vel_y[i] <= '0;
      end
    end else begin
      v_sync_q   <= v_sync;
      frame_done <= 1'b0;
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick && !pause) begin
            state <= LOAD;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          op_px <= pos_x[idx];
          op_py <= pos_y[idx];
          op_vx <= vel_x[idx];
          op_vy <= vel_y[idx];
          state <= CALC;
        end
        CALC: begin
          res_px <= alu_px;
          res_py <= alu_py;
          res_vx <= alu_vx;
          res_vy <= alu_vy;
          state  <= WRITE;
        end
        WRITE: begin
          pos_x[idx] <= res_px;
          pos_y[idx] <= res_py;
          vel_x[idx] <= res_vx;
          vel_y[idx] <= res_vy;
          if (idx == LAST_IDX) begin
            state      <= COMMIT;
            frame_done <= 1'b1;
            for (int i = 0; i < NUM_BALLS; i++) begin
              if (IDX_W'(i) == idx) begin
                ball_x[PIX_W*i +: PIX_W] <= res_px[FIX_W-1:2];
                ball_y[PIX_W*i +: PIX_W] <= res_py[FIX_W-1:2];
              end else begin
                ball_x[PIX_W*i +: PIX_W] <= pos_x[i][FIX_W-1:2];
                ball_y[PIX_W*i +: PIX_W] <= pos_y[i][FIX_W-1:2];
              end
            end
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= LOAD;
          end
        end
        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
